uart_tx: RTL and testbench

Byte-wide UART transmitter that drives the SOC's TXD pin. It replaces the current constant-0 tie-off.
- Accepts one byte per valid/ready handshake.
- Serialises the byte as 8N1: start bit, 8 data bits LSB first, stop bit.
- Bit timing comes from a fixed clocks-per-bit divider on the core clock clk.
- Feeds the existing UART RX/TX pin pair; later the RXD path receiver will pair with it for loopback.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and, later, the receiver.
//   - uart_state_t : framing state encoding (IDLE, START, DATA, PARITY, STOP)
//   - UART_DATA_BITS : data bits per frame
//   - UART_CLKS_PER_BIT_DEFAULT : default bit period (50 MHz core clock / 115200 baud)
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter for the UART.
// Counts 0..CLKS_PER_BIT-1 and raises o_tick for the single cycle in which the
// count is CLKS_PER_BIT-1, then wraps to 0. i_restart holds the count at 0, so
// the first period after restart is released is a full CLKS_PER_BIT cycles.
// Ports:
//   clk       : core clock
//   resetn    : synchronous active-low reset
//   i_restart : hold counter at 0
//   o_tick    : last cycle of the current bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_restart,
  output logic o_tick
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn || i_restart) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter driving the TXD pin.
// Accepts one byte per tx_valid/tx_ready handshake and sends it as
// start bit, 8 data bits LSB first, [even parity], stop bit. Each bit is held
// for CLKS_PER_BIT clk cycles. txd is registered and idles high.
// Build option: define UART_TX_PARITY_EN to insert an even parity bit between
// the last data bit and the stop bit (frame grows from 10 to 11 bit periods).
// Ports:
//   clk      : core clock
//   resetn   : synchronous active-low reset; aborts any frame in progress
//   tx_data  : byte to send, captured on the handshake edge only
//   tx_valid : producer has a byte
//   tx_ready : transmitter idle and able to accept a byte
//   txd      : serial output line
//   busy     : frame in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      txd,
  output logic                      busy
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               r_state, w_state_next;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
  logic [2:0]                r_bit_idx, w_bit_idx_next;
  logic                      r_txd, w_txd_next;
  logic                      w_tick;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity, w_parity_next;
`endif

  // The counter is held at zero while idle so the start bit gets a full period
  // counted from the handshake edge.
  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk       (clk),
    .resetn    (resetn),
    .i_restart (r_state == ST_IDLE),
    .o_tick    (w_tick)
  );

  // Decoded from the state register only: no path from tx_valid.
  assign tx_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign txd      = r_txd;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_next;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_txd_next     = r_txd;
`ifdef UART_TX_PARITY_EN
    w_parity_next  = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        if (tx_valid) begin
          w_state_next = ST_START;
          w_shift_next = tx_data;
          w_txd_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_next = ST_DATA;
          w_txd_next   = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = r_bit_idx + 3'd1;  // wraps to 0 after the last bit
          if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = ST_PARITY;
            w_txd_next   = r_parity;
`else
            w_state_next = ST_STOP;
            w_txd_next   = 1'b1;
`endif
          end else begin
            // Next bit is what will sit in bit 0 after this shift.
            w_txd_next = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state_next = ST_STOP;
          w_txd_next   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_txd_next   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Two instances: CLKS_PER_BIT=4 for the main scenarios and CLKS_PER_BIT=2 for
// the shortest legal bit period. Line activity is captured one sample per clk
// (at the falling edge) into a bit vector, sample 0 being the first cycle after
// the handshake, and compared against a frame built from the byte's bit list.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int N4 = 4;
  localparam int N2 = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] data4, data2;
  logic       valid4, valid2;
  logic       ready4, ready2, txd4, txd2, busy4, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N4)) dut4 (
    .clk(clk), .resetn(resetn), .tx_data(data4), .tx_valid(valid4),
    .tx_ready(ready4), .txd(txd4), .busy(busy4)
  );

  uart_tx #(.CLKS_PER_BIT(N2)) dut2 (
    .clk(clk), .resetn(resetn), .tx_data(data2), .tx_valid(valid2),
    .tx_ready(ready2), .txd(txd2), .busy(busy2)
  );

  // Expected line: bit list start, data LSB first, [even parity], stop; each
  // bit repeated n samples, followed by one idle-high sample.
  function automatic logic [63:0] model_line(input logic [7:0] b, input int n);
    logic       bits[$];
    logic [63:0] r;
    r = '0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    for (int k = 0; k < bits.size() * n; k++) r[k] = bits[k / n];
    r[bits.size() * n] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] model_busy(input int n);
    return (64'd1 << (FB * n)) - 64'd1;
  endfunction

  function automatic logic [63:0] model_ready(input int n);
    return 64'd1 << (FB * n);
  endfunction

  // Waits (bounded) for tx_ready, presents the byte, and returns just after the
  // transfer edge.
  task automatic handshake(input int which, input logic [7:0] b, input bit keep,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (((which == 4) ? ready4 : ready2) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (which == 4) begin data4 = b; valid4 = 1'b1; end
      else            begin data2 = b; valid2 = 1'b1; end
      @(posedge clk);
      #1;
      if (!keep) begin
        if (which == 4) valid4 = 1'b0;
        else            valid2 = 1'b0;
      end
    end
  endtask

  task automatic capture(input int which, input int n, output logic [63:0] ln,
                         output logic [63:0] bs, output logic [63:0] rd);
    ln = '0; bs = '0; rd = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ln[k] = (which == 4) ? txd4   : txd2;
      bs[k] = (which == 4) ? busy4  : busy2;
      rd[k] = (which == 4) ? ready4 : ready2;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; valid4 = 1'b0; valid2 = 1'b0; data4 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (txd4 !== 1'b1)   begin errors++; $display("FAIL reset_txd4 got %b want 1", txd4); end
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4 got %b want 1", ready4); end
    checks++; if (busy4 !== 1'b0)  begin errors++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    checks++; if (txd2 !== 1'b1)   begin errors++; $display("FAIL reset_txd2 got %b want 1", txd2); end
    checks++; if (busy2 !== 1'b0)  begin errors++; $display("FAIL reset_busy2 got %b want 0", busy2); end
    resetn = 1'b1;
    $display("reset released");
  endtask

  task automatic test_frames;
    logic [7:0]  b;
    logic [63:0] ln, bs, rd;
    bit          ok;
    for (int t = 0; t < 5; t++) begin
      b = (t == 0) ? 8'h55 : 8'($urandom_range(0, 255));
      handshake(4, b, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL frame_handshake got timeout want ready"); end
      capture(4, FB * N4 + 1, ln, bs, rd);
      $display("frame byte=%02h line=%h", b, ln);
      checks++; if (ln !== model_line(b, N4)) begin errors++; $display("FAIL frame_line byte=%02h got %h want %h", b, ln, model_line(b, N4)); end
      checks++; if (bs !== model_busy(N4))    begin errors++; $display("FAIL frame_busy byte=%02h got %h want %h", b, bs, model_busy(N4)); end
      checks++; if (rd !== model_ready(N4))   begin errors++; $display("FAIL frame_ready byte=%02h got %h want %h", b, rd, model_ready(N4)); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ln, bs, rd;
    bit          ok;
    handshake(4, 8'h80, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_handshake got timeout want ready"); end
    data4 = 8'h01;  // ignored by the frame in flight, taken at the next handshake
    capture(4, FB * N4 + 1, ln, bs, rd);
    $display("frame byte=80 line=%h", ln);
    checks++; if (ln !== model_line(8'h80, N4)) begin errors++; $display("FAIL b2b_first_line got %h want %h", ln, model_line(8'h80, N4)); end
    checks++; if (rd !== model_ready(N4))       begin errors++; $display("FAIL b2b_first_ready got %h want %h", rd, model_ready(N4)); end
    @(posedge clk);
    #1 valid4 = 1'b0;
    capture(4, FB * N4 + 1, ln, bs, rd);
    $display("frame byte=01 line=%h", ln);
    checks++; if (ln !== model_line(8'h01, N4)) begin errors++; $display("FAIL b2b_second_line got %h want %h", ln, model_line(8'h01, N4)); end
    checks++; if (bs !== model_busy(N4))        begin errors++; $display("FAIL b2b_second_busy got %h want %h", bs, model_busy(N4)); end
  endtask

  task automatic test_hold_off;
    logic [7:0]  b1, b2;
    logic [63:0] ln, ln2, bs, bs2, rd, rd2;
    bit          ok;
    b1 = 8'($urandom_range(0, 255));
    b2 = ~b1;
    handshake(4, b1, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_handshake got timeout want ready"); end
    capture(4, 15, ln, bs, rd);
    data4 = b2;
    capture(4, FB * N4 + 1 - 15, ln2, bs2, rd2);
    ln = ln | (ln2 << 15);
    rd = rd | (rd2 << 15);
    $display("frame byte=%02h (data changed to %02h mid-frame) line=%h", b1, b2, ln);
    checks++; if (ln !== model_line(b1, N4)) begin errors++; $display("FAIL hold_line got %h want %h", ln, model_line(b1, N4)); end
    checks++; if (rd !== model_ready(N4))    begin errors++; $display("FAIL hold_ready got %h want %h", rd, model_ready(N4)); end
    @(posedge clk);
    #1 valid4 = 1'b0;
    capture(4, FB * N4 + 1, ln, bs, rd);
    $display("frame byte=%02h line=%h", b2, ln);
    checks++; if (ln !== model_line(b2, N4)) begin errors++; $display("FAIL hold_second_line got %h want %h", ln, model_line(b2, N4)); end
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] ln, bs, rd, mask;
    bit          ok;
    handshake(4, 8'hA3, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_handshake got timeout want ready"); end
    capture(4, 18, ln, bs, rd);  // up to the middle of data bit 3
    mask = (64'd1 << 18) - 64'd1;
    checks++; if (ln !== (model_line(8'hA3, N4) & mask)) begin errors++; $display("FAIL midrst_partial got %h want %h", ln, model_line(8'hA3, N4) & mask); end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (txd4 !== 1'b1)   begin errors++; $display("FAIL midrst_txd got %b want 1", txd4); end
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready4); end
    checks++; if (busy4 !== 1'b0)  begin errors++; $display("FAIL midrst_busy got %b want 0", busy4); end
    @(negedge clk);
    resetn = 1'b1;
    $display("frame byte=a3 aborted by reset");
    handshake(4, 8'h0F, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_resend got timeout want ready"); end
    capture(4, FB * N4 + 1, ln, bs, rd);
    $display("frame byte=0f line=%h", ln);
    checks++; if (ln !== model_line(8'h0F, N4)) begin errors++; $display("FAIL midrst_clean_line got %h want %h", ln, model_line(8'h0F, N4)); end
    checks++; if (bs !== model_busy(N4))        begin errors++; $display("FAIL midrst_clean_busy got %h want %h", bs, model_busy(N4)); end
  endtask

  task automatic test_min_period;
    logic [7:0]  b;
    logic [63:0] ln, bs, rd;
    bit          ok;
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      handshake(2, b, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL n2_handshake got timeout want ready"); end
      capture(2, FB * N2 + 1, ln, bs, rd);
      $display("frame n=2 byte=%02h line=%h", b, ln);
      checks++; if (ln !== model_line(b, N2)) begin errors++; $display("FAIL n2_line byte=%02h got %h want %h", b, ln, model_line(b, N2)); end
      checks++; if (bs !== model_busy(N2))    begin errors++; $display("FAIL n2_busy byte=%02h got %h want %h", b, bs, model_busy(N2)); end
      if (t == 0) begin
        checks++; if (ln[2:0] !== 3'b100) begin errors++; $display("FAIL n2_start_len got %b want 100", ln[2:0]); end
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [63:0] ln, bs, rd;
    bit          ok;
    handshake(4, 8'h07, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL par_handshake got timeout want ready"); end
    capture(4, FB * N4 + 1, ln, bs, rd);
    $display("frame parity byte=07 line=%h", ln);
    checks++; if (ln[9*N4] !== 1'b1)          begin errors++; $display("FAIL par_bit_07 got %b want 1", ln[9*N4]); end
    checks++; if (bs !== ((64'd1 << 44) - 64'd1)) begin errors++; $display("FAIL par_len_07 got %h want 44 ones", bs); end
    handshake(4, 8'h03, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL par_handshake2 got timeout want ready"); end
    capture(4, FB * N4 + 1, ln, bs, rd);
    $display("frame parity byte=03 line=%h", ln);
    checks++; if (ln[9*N4] !== 1'b0)           begin errors++; $display("FAIL par_bit_03 got %b want 0", ln[9*N4]); end
    checks++; if (ln !== model_line(8'h03, N4)) begin errors++; $display("FAIL par_line_03 got %h want %h", ln, model_line(8'h03, N4)); end
  endtask
`endif

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_hold_off();
    test_reset_mid_frame();
    test_min_period();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
